// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory request/response channel, redirect
// input and the decode-side valid/ready channel.
interface instr_fetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport master (
    input  redirect, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  out_ready,
    output imem_req_valid, imem_req_addr,
    output out_valid, out_instr, out_pc
  );

  modport slave (
    output redirect, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output out_ready,
    input  imem_req_valid, imem_req_addr,
    input  out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: credit-limited sequential fetch into a PC-tagged
// FIFO, with redirect flush and discard of stale in-flight responses.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, rsp_pc;
  logic [CW-1:0] count, outstanding, drop, drop_next;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_base;
  logic          req_fire, rsp_fire, push, pop;
  logic          redirect_pc_unused;

  assign redirect_base      = {bus.redirect_pc[31:2], 2'b00};
  assign redirect_pc_unused = ^bus.redirect_pc[1:0];

  // Buffered plus in-flight never exceeds DEPTH, so every accepted response has a slot.
  assign credit_used        = {1'b0, count} + {1'b0, outstanding};
  assign bus.imem_req_valid = !rst && !bus.redirect && (credit_used < (CW+1)'(DEPTH));
  assign bus.imem_req_addr  = fetch_pc;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_fire = bus.imem_rsp_valid;
  assign push     = rsp_fire && !bus.redirect && (state == FETCH);
  assign pop      = bus.out_valid && bus.out_ready;

  assign bus.out_valid = !rst && (count != '0);
  assign bus.out_instr = instr_q[rd_ptr];
  assign bus.out_pc    = pc_q[rd_ptr];

  always_comb begin
    state_next = state;
    drop_next  = drop;
    if (bus.redirect) begin
      drop_next  = outstanding - CW'(rsp_fire);
      state_next = (drop_next != '0) ? DRAIN : FETCH;
    end else if (state == DRAIN && rsp_fire) begin
      drop_next = drop - CW'(1);
      if (drop == CW'(1))
        state_next = FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      drop  <= '0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
      if (bus.redirect) begin
        fetch_pc <= redirect_base;
        rsp_pc   <= redirect_base;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= bus.imem_rsp_data;
      pc_q[wr_ptr]    <= rsp_pc;
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(push && count == CW'(DEPTH)));
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage between the program counter and decode.
- Issues sequential word fetches to instruction memory over a request/response interface, buffering up to DEPTH instructions, each tagged with its PC.
- Handles redirects (branch/jump) by flushing the queue and discarding stale in-flight responses.
- Presents instructions to decode over a valid/ready handshake.

Parameters:
- DEPTH, 4: queue entries; also the max of (buffered + outstanding) requests. Power of two, at least 2.
- RESET_PC, 32'h0000_0000: fetch address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- redirect  in  1  pulse: restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored and forced to 0
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response data valid; responses are in order and cannot be back-pressured
- imem_rsp_data  in  32  fetched instruction
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head entry
- out_instr  out  32  head instruction
- out_pc  out  32  PC of head instruction

Behaviour:
- State:
  - fetch_pc: next request address.
  - rsp_pc: PC of next accepted response.
  - count: 0..DEPTH.
  - outstanding: 0..DEPTH.
  - drop: 0..DEPTH, responses still to discard.
  - FSM {FETCH, DRAIN}.
- Reset (async): fetch_pc = rsp_pc = RESET_PC; count = outstanding = drop = 0; FSM = FETCH; queue pointers 0. While rst is high, imem_req_valid = 0 and out_valid = 0.
- Request issue: imem_req_valid = !redirect && (count + outstanding < DEPTH); imem_req_addr = fetch_pc.
  - On a request handshake: fetch_pc += 4 (wraps mod 2^32); outstanding += 1.
  - Requests may be withdrawn or changed on any cycle. There is no hold rule.
- Response, FSM = FETCH: on imem_rsp_valid, push {rsp_pc, imem_rsp_data}, then rsp_pc += 4, outstanding -= 1.
- Response, FSM = DRAIN: on imem_rsp_valid, discard the data; drop -= 1; outstanding -= 1. When drop reaches 0, return to FETCH in the next cycle.
- Credit rule guarantees that a pushed response always has space. A push into a full queue is an assertion failure.
- Output: out_valid = (count != 0); out_instr and out_pc are the head entry, stable while out_valid && !out_ready.
  - On out_valid && out_ready: pop.
  - Push and pop in the same cycle leave count unchanged.
- Redirect (priority over everything else that cycle):
  - No request is issued (imem_req_valid = 0).
  - Queue flushed: count = 0, pointers reset.
  - fetch_pc = rsp_pc = {redirect_pc[31:2], 2'b00}.
  - A response arriving in the redirect cycle is discarded.
  - drop = outstanding after counting that cycle's response. FSM = DRAIN if drop != 0, else FETCH.
  - An output handshake in the redirect cycle counts as consumed by decode; the entry is not re-presented.
- Redirect during DRAIN: drop recomputed as the current outstanding (minus any response this cycle); rsp_pc and fetch_pc reloaded.
- Latency: zero-wait memory (ready = 1, response the cycle after request) gives the first out_valid 2 cycles after reset release. Steady state is 1 instruction per cycle.
- Throughput limit: with DEPTH outstanding and a full queue, requests stop until a pop frees credit.

Test Plan:
- Reset, then ready = 1, 1-cycle-latency memory returning addr^32'hA5A5_0000, out_ready = 1 → out_pc sequence 0x0, 0x4, 0x8, 0xC with matching data, one per cycle after the first.
- out_ready = 0 for 10 cycles → exactly DEPTH = 4 requests issued, then imem_req_valid = 0 and count = 4. Then out_ready = 1 → entries pop in order and requests resume.
- Redirect to 0x100 while 2 requests are outstanding (3-cycle latency) → next 2 responses dropped; first out_pc = 0x100 with data fetched from 0x100; no stale entry reaches the output.
- Redirect to 0x203 with the queue holding 3 entries → queue empties next cycle; next request addr = 0x200; out_pc = 0x200.
- Redirect in the same cycle as imem_rsp_valid and an out handshake → response discarded, popped entry not re-presented, drop = outstanding − 1.
- rst asserted mid-stream with 2 outstanding → outputs 0 immediately. After release, fetch restarts at RESET_PC; late responses after release are a memory-model reset requirement, so the bench resets the memory too.
